mips_fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of the instruction memory in the MIPS single-cycle datapath. It owns the program counter and drives `imem_addr`. It returns the fetched word with a valid flag. It selects the next PC from sequential, branch, jump and jump-register sources, and traps misaligned or out-of-range targets into a sticky fault state.

---
 rtl/mips_fetch_pkg.sv | 13 +
 rtl/mips_fetch_if.sv | 30 +++
 rtl/mips_next_pc.sv | 49 ++++
 rtl/mips_fetch_unit.sv | 109 ++++++++++
 tb/tb_mips_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/mips_fetch_if.sv
// Control and instruction-memory bundle between the datapath and the fetch stage.
// master: datapath / instruction memory side; slave: the fetch unit.
interface mips_fetch_if;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        fault;

    modport master (
        output stall, branch_taken, branch_imm, jump, jump_index,
               jump_reg, jr_target, imem_instr,
        input  imem_addr, instr, pc, pc_plus4, fetch_valid, fault
    );

    modport slave (
        input  stall, branch_taken, branch_imm, jump, jump_index,
               jump_reg, jr_target, imem_instr,
        output imem_addr, instr, pc, pc_plus4, fetch_valid, fault
    );
endinterface

// File: rtl/mips_next_pc.sv
// Next-PC selection: priority mux over stall / jr / j / branch / sequential,
// target arithmetic and alignment / range check of the chosen target.
module mips_next_pc
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_BYTES = 4096
) (
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus4_i,
    input  logic        stall_i,
    input  logic        jump_reg_i,
    input  logic [31:0] jr_target_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_imm_i,
    output logic [31:0] next_pc_o,
    output logic        next_fault_o
);

    localparam logic [31:0] IMEM_SIZE = 32'(IMEM_BYTES);

    logic [31:0] branch_off;
    logic [31:0] target;
    logic [31:0] rel_off;

    assign branch_off = {{14{branch_imm_i[15]}}, branch_imm_i, 2'b00};
    assign rel_off    = target - RESET_PC;

    // Pick the redirect target by priority; a stall holds the PC and masks the check.
    always_comb begin
        target       = pc_plus4_i;
        next_pc_o    = pc_i;
        next_fault_o = 1'b0;
        if (jump_reg_i) begin
            target = jr_target_i;
        end else if (jump_i) begin
            target = {pc_plus4_i[31:28], jump_index_i, 2'b00};
        end else if (branch_taken_i) begin
            target = pc_plus4_i + branch_off;
        end
        if (!stall_i) begin
            next_pc_o    = target;
            next_fault_o = (target[1:0] != 2'b00) || (rel_off >= IMEM_SIZE);
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage: PC register, BOOT/RUN/FAULT sequencing,
// instruction gating. Optional perf counters under `MIPS_FETCH_PERF_EN.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_BYTES = 4096
) (
    input  logic         clk,
    input  logic         reset,
    mips_fetch_if.slave  bus
`ifdef MIPS_FETCH_PERF_EN
    ,
    output logic [31:0]  perf_cycles,
    output logic [31:0]  perf_fetches
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;
    logic         next_fault;
    logic         fetch_valid;
    logic [31:0]  instr;

    assign pc_plus4 = pc_q + 32'd4;

    mips_next_pc #(
        .RESET_PC   (RESET_PC),
        .IMEM_BYTES (IMEM_BYTES)
    ) u_next_pc (
        .pc_i           (pc_q),
        .pc_plus4_i     (pc_plus4),
        .stall_i        (bus.stall),
        .jump_reg_i     (bus.jump_reg),
        .jr_target_i    (bus.jr_target),
        .jump_i         (bus.jump),
        .jump_index_i   (bus.jump_index),
        .branch_taken_i (bus.branch_taken),
        .branch_imm_i   (bus.branch_imm),
        .next_pc_o      (next_pc),
        .next_fault_o   (next_fault)
    );

    // State and PC registers; reset dominates every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state / PC and state-gated outputs; a faulting target is never loaded.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_valid = 1'b0;
        instr       = NOP_INSTR;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                fetch_valid = 1'b1;
                instr       = bus.imem_instr;
                if (next_fault) begin
                    state_d = FAULT;
                end else begin
                    pc_d = next_pc;
                end
            end
            FAULT: state_d = FAULT;
            default: state_d = BOOT;
        endcase
    end

    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.fetch_valid = fetch_valid;
    assign bus.instr       = instr;
    assign bus.fault       = (state_q == FAULT);

`ifdef MIPS_FETCH_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_fetches_q;

    // Saturating activity counters: cycles out of BOOT, and non-stalled valid fetches.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles_q  <= 32'd0;
            perf_fetches_q <= 32'd0;
        end else begin
            if ((state_q != BOOT) && (perf_cycles_q != 32'hFFFF_FFFF)) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if (fetch_valid && !bus.stall && (perf_fetches_q != 32'hFFFF_FFFF)) begin
                perf_fetches_q <= perf_fetches_q + 32'd1;
            end
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_fetches = perf_fetches_q;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed scenarios plus a randomized
// run against a behavioural model of the fetch rules.
module tb_mips_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          MEM_B  = 4096;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    logic [31:0] mem [1024];

    mips_fetch_if bus ();

`ifdef MIPS_FETCH_PERF_EN
    logic [31:0] perf_cycles;
    logic [31:0] perf_fetches;
`endif

    mips_fetch_unit #(.RESET_PC(RST_PC), .IMEM_BYTES(MEM_B)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MIPS_FETCH_PERF_EN
        ,
        .perf_cycles  (perf_cycles),
        .perf_fetches (perf_fetches)
`endif
    );

    assign bus.imem_instr = mem[bus.imem_addr[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: 0 = booting, 1 = running, 2 = trapped
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_cyc;
    logic [31:0] m_fet;

    task automatic idle();
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_imm   = 16'h0;
        bus.jump         = 1'b0;
        bus.jump_index   = 26'h0;
        bus.jump_reg     = 1'b0;
        bus.jr_target    = 32'h0;
    endtask

    task automatic model_step();
        logic [31:0] p4;
        logic [31:0] t;
        if (reset) begin
            m_state = 0;
            m_pc    = RST_PC;
            m_cyc   = 0;
            m_fet   = 0;
            return;
        end
        if (m_state != 0 && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
        if (m_state == 1 && !bus.stall && m_fet != 32'hFFFF_FFFF) m_fet = m_fet + 1;
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1 && !bus.stall) begin
            p4 = m_pc + 4;
            if (bus.jump_reg)          t = bus.jr_target;
            else if (bus.jump)         t = (p4 & 32'hF000_0000) | (32'(bus.jump_index) * 4);
            else if (bus.branch_taken) t = p4 + 32'(int'($signed(bus.branch_imm)) * 4);
            else                       t = p4;
            if ((t % 4) != 0 || (t - RST_PC) >= 32'(MEM_B)) m_state = 2;
            else                                           m_pc = t;
        end
    endtask

    // Apply current inputs on the next edge, then settle.
    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        advance();
        advance();
        tests++; if (bus.fetch_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.fetch_valid); end
        tests++; if (bus.fault !== 1'b0) begin fails++; $display("FAIL reset_fault got %b want 0", bus.fault); end
        tests++; if (bus.instr !== 32'h0) begin fails++; $display("FAIL reset_instr got %h want 0", bus.instr); end
        reset = 1'b0;
        tests++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL boot_pc got %h want 0", bus.pc); end
        tests++; if (bus.fetch_valid !== 1'b0) begin fails++; $display("FAIL boot_valid got %b want 0", bus.fetch_valid); end
        advance();
        tests++; if (bus.fetch_valid !== 1'b1) begin fails++; $display("FAIL first_valid got %b want 1", bus.fetch_valid); end
        tests++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL first_pc got %h want 0", bus.pc); end
        tests++; if (bus.instr !== mem[0]) begin fails++; $display("FAIL first_instr got %h want %h", bus.instr, mem[0]); end
        for (int i = 1; i <= 3; i++) begin
            advance();
            tests++;
            if (bus.pc !== 32'(i * 4)) begin fails++; $display("FAIL seq_pc got %h want %h", bus.pc, 32'(i * 4)); end
            tests++;
            if (bus.pc_plus4 !== 32'(i * 4 + 4)) begin fails++; $display("FAIL seq_pc_plus4 got %h want %h", bus.pc_plus4, 32'(i * 4 + 4)); end
        end
    endtask

    task automatic test_branch();
        idle(); bus.jump_reg = 1'b1; bus.jr_target = 32'h10;
        advance();
        tests++; if (bus.pc !== 32'h10) begin fails++; $display("FAIL jr_to_10 got %h want 10", bus.pc); end
        idle(); bus.branch_taken = 1'b1; bus.branch_imm = 16'hFFFC;
        advance();
        tests++; if (bus.pc !== 32'h04) begin fails++; $display("FAIL branch_back got %h want 04", bus.pc); end
        idle(); bus.jump_reg = 1'b1; bus.jr_target = 32'h10;
        advance();
        idle(); bus.branch_taken = 1'b1; bus.branch_imm = 16'd3;
        advance();
        tests++; if (bus.pc !== 32'h20) begin fails++; $display("FAIL branch_fwd got %h want 20", bus.pc); end
        tests++; if (bus.instr !== mem[8]) begin fails++; $display("FAIL branch_instr got %h want %h", bus.instr, mem[8]); end
    endtask

    task automatic test_jump();
        idle(); bus.jump_reg = 1'b1; bus.jr_target = 32'h40;
        advance();
        idle(); bus.jump = 1'b1; bus.jump_index = 26'h10;
        advance();
        tests++; if (bus.pc !== 32'h40) begin fails++; $display("FAIL jump_pc got %h want 40", bus.pc); end
        bus.jump_reg = 1'b1; bus.jr_target = 32'h80; bus.branch_taken = 1'b1; bus.branch_imm = 16'd5;
        advance();
        tests++; if (bus.pc !== 32'h80) begin fails++; $display("FAIL jr_priority got %h want 80", bus.pc); end
        idle(); bus.jump = 1'b1; bus.jump_index = 26'h30; bus.branch_taken = 1'b1; bus.branch_imm = 16'd1;
        advance();
        tests++; if (bus.pc !== 32'hC0) begin fails++; $display("FAIL jump_over_branch got %h want c0", bus.pc); end
        idle(); bus.jump_reg = 1'b1; bus.jr_target = 32'h80;
        advance();
    endtask

    task automatic test_stall();
        idle(); bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_imm = 16'd3;
        for (int i = 0; i < 3; i++) begin
            advance();
            tests++; if (bus.pc !== 32'h80) begin fails++; $display("FAIL stall_pc got %h want 80", bus.pc); end
            tests++; if (bus.fetch_valid !== 1'b1) begin fails++; $display("FAIL stall_valid got %b want 1", bus.fetch_valid); end
            tests++; if (bus.fault !== 1'b0) begin fails++; $display("FAIL stall_fault got %b want 0", bus.fault); end
        end
        idle(); bus.stall = 1'b1; bus.jump_reg = 1'b1; bus.jr_target = 32'h102;
        advance();
        tests++; if (bus.fault !== 1'b0) begin fails++; $display("FAIL stall_masks_fault got %b want 0", bus.fault); end
        tests++; if (bus.pc !== 32'h80) begin fails++; $display("FAIL stall_masks_pc got %h want 80", bus.pc); end
        idle();
    endtask

    task automatic test_fault();
        idle(); bus.jump_reg = 1'b1; bus.jr_target = 32'h102;
        advance();
        tests++; if (bus.fault !== 1'b1) begin fails++; $display("FAIL misalign_fault got %b want 1", bus.fault); end
        tests++; if (bus.fetch_valid !== 1'b0) begin fails++; $display("FAIL fault_valid got %b want 0", bus.fetch_valid); end
        tests++; if (bus.instr !== 32'h0) begin fails++; $display("FAIL fault_instr got %h want 0", bus.instr); end
        tests++; if (bus.pc !== 32'h80) begin fails++; $display("FAIL fault_pc got %h want 80", bus.pc); end
        idle(); bus.jump_reg = 1'b1; bus.jr_target = 32'h20; bus.jump = 1'b1; bus.branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            advance();
            tests++; if (bus.pc !== 32'h80) begin fails++; $display("FAIL fault_frozen_pc got %h want 80", bus.pc); end
            tests++; if (bus.fault !== 1'b1) begin fails++; $display("FAIL fault_sticky got %b want 1", bus.fault); end
        end
        reset = 1'b1;
        advance();
        reset = 1'b0;
        tests++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL fault_reset_pc got %h want 0", bus.pc); end
        tests++; if (bus.fault !== 1'b0) begin fails++; $display("FAIL fault_reset_fault got %b want 0", bus.fault); end
        idle();
        advance();
        bus.jump_reg = 1'b1; bus.jr_target = 32'h1000;
        advance();
        tests++; if (bus.fault !== 1'b1) begin fails++; $display("FAIL range_fault got %b want 1", bus.fault); end
        tests++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL range_pc got %h want 0", bus.pc); end
        idle();
    endtask

    task automatic test_seq_run();
        idle();
        reset = 1'b1;
        advance();
        reset = 1'b0;
        advance();
        for (int i = 0; i < 1023; i++) advance();
        tests++; if (bus.pc !== 32'hFFC) begin fails++; $display("FAIL seq_last_pc got %h want ffc", bus.pc); end
        tests++; if (bus.fault !== 1'b0) begin fails++; $display("FAIL seq_last_fault got %b want 0", bus.fault); end
        advance();
        tests++; if (bus.fault !== 1'b1) begin fails++; $display("FAIL seq_overrun_fault got %b want 1", bus.fault); end
        tests++; if (bus.pc !== 32'hFFC) begin fails++; $display("FAIL seq_overrun_pc got %h want ffc", bus.pc); end
`ifdef MIPS_FETCH_PERF_EN
        tests++; if (perf_fetches !== 32'd1024) begin fails++; $display("FAIL perf_fetches got %0d want 1024", perf_fetches); end
        tests++; if (perf_cycles !== 32'd1024) begin fails++; $display("FAIL perf_cycles got %0d want 1024", perf_cycles); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] exp_instr;
        idle();
        reset = 1'b1;
        advance();
        reset = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            reset            = ($urandom_range(0, 79) == 0);
            bus.stall        = ($urandom_range(0, 3) == 0);
            bus.jump_reg     = ($urandom_range(0, 7) == 0);
            bus.jr_target    = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1023) * 4);
            bus.jump         = ($urandom_range(0, 7) == 0);
            bus.jump_index   = ($urandom_range(0, 15) == 0) ? 26'($urandom) : 26'($urandom_range(0, 1023));
            bus.branch_taken = ($urandom_range(0, 3) == 0);
            bus.branch_imm   = 16'($urandom_range(0, 63) - 32);
            advance();
            exp_instr = (m_state == 1) ? mem[(m_pc % 32'(MEM_B)) / 4] : 32'h0;
            tests++; if (bus.pc !== m_pc) begin fails++; $display("FAIL rnd_pc cyc %0d got %h want %h", n, bus.pc, m_pc); end
            tests++; if (bus.imem_addr !== m_pc) begin fails++; $display("FAIL rnd_imem_addr cyc %0d got %h want %h", n, bus.imem_addr, m_pc); end
            tests++; if (bus.pc_plus4 !== m_pc + 32'd4) begin fails++; $display("FAIL rnd_pc_plus4 cyc %0d got %h want %h", n, bus.pc_plus4, m_pc + 32'd4); end
            tests++; if (bus.fetch_valid !== (m_state == 1)) begin fails++; $display("FAIL rnd_valid cyc %0d got %b want %b", n, bus.fetch_valid, m_state == 1); end
            tests++; if (bus.fault !== (m_state == 2)) begin fails++; $display("FAIL rnd_fault cyc %0d got %b want %b", n, bus.fault, m_state == 2); end
            tests++; if (bus.instr !== exp_instr) begin fails++; $display("FAIL rnd_instr cyc %0d got %h want %h", n, bus.instr, exp_instr); end
`ifdef MIPS_FETCH_PERF_EN
            tests++; if (perf_cycles !== m_cyc) begin fails++; $display("FAIL rnd_perf_cycles cyc %0d got %0d want %0d", n, perf_cycles, m_cyc); end
            tests++; if (perf_fetches !== m_fet) begin fails++; $display("FAIL rnd_perf_fetches cyc %0d got %0d want %0d", n, perf_fetches, m_fet); end
`endif
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tests   = 0;
        fails   = 0;
        m_state = 0;
        m_pc    = RST_PC;
        m_cyc   = 0;
        m_fet   = 0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom | 32'h1;
        reset = 1'b1;
        idle();
        @(negedge clk);
        test_reset();
        test_branch();
        test_jump();
        test_stall();
        test_fault();
        test_seq_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
